// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared defaults and clog2 for width derivation
package dff_pipe_pkg;
  localparam int DEF_DW = 8;
  localparam int DEF_DEPTH = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/dff_en_rst.sv
// dff_en_rst: W-bit register, async reset to RST_VAL, enable/hold; in i_clk/i_rst/i_en/i_d, out o_q
module dff_en_rst #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q, r_d;
  always_comb r_d = i_en ? i_d : r_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_q <= RST_VAL;
    else r_q <= r_d;
  assign o_q = r_q;
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DW x DEPTH stallable delay pipe with valid/flush/tap/count; in i_clk/i_rst/i_en/i_flush/i_d/i_vld/i_sel, out o_q/o_vld/o_tap/o_tap_vld/o_cnt
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [DW-1:0] RST_VAL = '0,
  parameter int SW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
  parameter int CW = clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_flush,
  input  logic [DW-1:0] i_d,
  input  logic          i_vld,
  input  logic [SW-1:0] i_sel,
  output logic [DW-1:0] o_q,
  output logic          o_vld,
  output logic [DW-1:0] o_tap,
  output logic          o_tap_vld,
  output logic [CW-1:0] o_cnt
);
  logic [DW-1:0] stage_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DW-1:0] tap_arr [2**SW];
  logic [2**SW-1:0] tap_vld_arr;
  logic [CW-1:0] cnt_q, cnt_d;
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [DW-1:0] d_in;
    logic v_in;
    if (g == 0) begin : g_head
      assign d_in = i_d;
      assign v_in = i_vld;
    end else begin : g_body
      assign d_in = stage_q[g-1];
      assign v_in = vld_q[g-1];
    end
    dff_en_rst #(.W(DW), .RST_VAL(RST_VAL)) u_data (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_d(d_in), .o_q(stage_q[g])
    );
    // valid bits also load on flush so a stalled flush still empties the pipe
    dff_en_rst #(.W(1), .RST_VAL(1'b0)) u_vld (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en | i_flush), .i_d(v_in & ~i_flush), .o_q(vld_q[g])
    );
  end
  // tap table padded to 2**SW so out-of-range selects read RST_VAL/invalid
  for (genvar t = 0; t < 2**SW; t++) begin : g_tap
    if (t < DEPTH) begin : g_live
      assign tap_arr[t] = stage_q[t];
      assign tap_vld_arr[t] = vld_q[t];
    end else begin : g_pad
      assign tap_arr[t] = RST_VAL;
      assign tap_vld_arr[t] = 1'b0;
    end
  end
  always_comb cnt_d = i_flush ? '0 : i_en ? cnt_q + CW'(i_vld) - CW'(vld_q[DEPTH-1]) : cnt_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_q = stage_q[DEPTH-1];
  assign o_vld = vld_q[DEPTH-1];
  assign o_tap = tap_arr[i_sel];
  assign o_tap_vld = tap_vld_arr[i_sel];
  assign o_cnt = cnt_q;
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: randomized self-checking bench for dff_pipe at DEPTH 4 and 5
module tb_dff_pipe;
  logic clk, rst, en, flush, vld;
  logic [7:0] d;
  logic [1:0] sel4;
  logic [2:0] sel5;
  logic [7:0] q4, tap4, q5, tap5;
  logic qv4, tv4, qv5, tv5;
  logic [2:0] cnt4, cnt5;
  int checks = 0;
  int failures = 0;
  logic [7:0] m4 [4];
  logic [7:0] m5 [5];
  logic [3:0] v4;
  logic [4:0] v5;
  localparam logic [7:0] RV5 = 8'hE7;

  dff_pipe #(.DW(8), .DEPTH(4), .RST_VAL(8'h00)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_flush(flush), .i_d(d), .i_vld(vld), .i_sel(sel4),
    .o_q(q4), .o_vld(qv4), .o_tap(tap4), .o_tap_vld(tv4), .o_cnt(cnt4)
  );
  dff_pipe #(.DW(8), .DEPTH(5), .RST_VAL(RV5)) u_dut5 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_flush(flush), .i_d(d), .i_vld(vld), .i_sel(sel5),
    .o_q(q5), .o_vld(qv5), .o_tap(tap5), .o_tap_vld(tv5), .o_cnt(cnt5)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m4[k] = 8'h00;
    for (int k = 0; k < 5; k++) m5[k] = RV5;
    v4 = '0;
    v5 = '0;
  endtask

  // advance one edge and apply the same edge to the reference pipes
  task automatic tick();
    @(posedge clk);
    if (en) begin
      for (int k = 3; k > 0; k--) m4[k] = m4[k-1];
      for (int k = 4; k > 0; k--) m5[k] = m5[k-1];
      m4[0] = d;
      m5[0] = d;
      v4 = {v4[2:0], vld};
      v5 = {v5[3:0], vld};
    end
    if (flush) begin
      v4 = '0;
      v5 = '0;
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (q4 !== 8'h00) begin failures++; $display("FAIL reset_q4 got=%h exp=00", q4); end
    checks++; if (qv4 !== 1'b0) begin failures++; $display("FAIL reset_vld4 got=%b exp=0", qv4); end
    checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL reset_cnt4 got=%0d exp=0", cnt4); end
    checks++; if (q5 !== RV5) begin failures++; $display("FAIL reset_q5 got=%h exp=%h", q5, RV5); end
    @(negedge clk);
    rst = 0;
    model_reset();
    en = 1;
    vld = 1;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      tick();
    end
    checks++; if (cnt4 !== 3'd3) begin failures++; $display("FAIL fill3_cnt got=%0d exp=3", cnt4); end
    rst = 1;
    #1;
    checks++; if (q4 !== 8'h00) begin failures++; $display("FAIL midrst_q got=%h exp=00", q4); end
    checks++; if (qv4 !== 1'b0) begin failures++; $display("FAIL midrst_vld got=%b exp=0", qv4); end
    checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", cnt4); end
    checks++; if (tap4 !== 8'h00 || tv4 !== 1'b0) begin failures++; $display("FAIL midrst_tap got=%h/%b exp=00/0", tap4, tv4); end
    model_reset();
    @(negedge clk);
    rst = 0;
    vld = 0;
    en = 0;
  endtask

  task automatic test_latency();
    en = 1;
    vld = 1;
    d = 8'hA5;
    sel4 = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (qv4 !== (i == 4)) begin failures++; $display("FAIL lat_vld edge=%0d got=%b exp=%b", i, qv4, i == 4); end
      checks++; if (cnt4 !== ((i <= 4) ? 3'd1 : 3'd0)) begin failures++; $display("FAIL lat_cnt edge=%0d got=%0d exp=%0d", i, cnt4, (i <= 4) ? 1 : 0); end
      if (i == 4) begin
        checks++; if (q4 !== 8'hA5) begin failures++; $display("FAIL lat_q got=%h exp=a5", q4); end
      end
      vld = 0;
      d = 8'($urandom);
    end
  endtask

  task automatic test_stall();
    en = 1;
    vld = 1;
    d = 8'h3C;
    tick();
    checks++; if (cnt4 !== 3'd1) begin failures++; $display("FAIL stall_cnt0 got=%0d exp=1", cnt4); end
    en = 0;
    for (int i = 2; i <= 4; i++) begin
      d = 8'($urandom);
      tick();
      checks++; if (cnt4 !== 3'd1) begin failures++; $display("FAIL stall_cnt edge=%0d got=%0d exp=1", i, cnt4); end
      checks++; if (qv4 !== 1'b0) begin failures++; $display("FAIL stall_vld edge=%0d got=%b exp=0", i, qv4); end
    end
    en = 1;
    vld = 0;
    for (int i = 5; i <= 7; i++) begin
      d = 8'($urandom);
      tick();
      checks++; if (qv4 !== (i == 7)) begin failures++; $display("FAIL stall_ovld edge=%0d got=%b exp=%b", i, qv4, i == 7); end
      if (i == 7) begin
        checks++; if (q4 !== 8'h3C) begin failures++; $display("FAIL stall_q got=%h exp=3c", q4); end
      end
    end
  endtask

  task automatic test_flush();
    logic [7:0] exp_f [4];
    exp_f = '{8'h55, 8'h04, 8'h03, 8'h02};
    en = 1;
    vld = 1;
    for (int k = 1; k <= 4; k++) begin
      d = 8'(k);
      tick();
    end
    checks++; if (cnt4 !== 3'd4) begin failures++; $display("FAIL flush_full_cnt got=%0d exp=4", cnt4); end
    checks++; if (q4 !== 8'h01) begin failures++; $display("FAIL flush_full_q got=%h exp=01", q4); end
    flush = 1;
    d = 8'h55;
    tick();
    flush = 0;
    vld = 0;
    checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL flush_cnt got=%0d exp=0", cnt4); end
    checks++; if (qv4 !== 1'b0) begin failures++; $display("FAIL flush_vld got=%b exp=0", qv4); end
    checks++; if (q4 !== 8'h02) begin failures++; $display("FAIL flush_q got=%h exp=02", q4); end
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      #1;
      checks++; if (tap4 !== exp_f[s] || tv4 !== 1'b0) begin failures++; $display("FAIL flush_tap sel=%0d got=%h/%b exp=%h/0", s, tap4, tv4, exp_f[s]); end
    end
  endtask

  task automatic test_steady();
    en = 1;
    vld = 1;
    for (int i = 1; i <= 8; i++) begin
      d = 8'($urandom);
      tick();
      checks++; if (cnt4 !== 3'((i < 4) ? i : 4)) begin failures++; $display("FAIL steady_cnt i=%0d got=%0d exp=%0d", i, cnt4, (i < 4) ? i : 4); end
      checks++; if (qv4 !== (i >= 4)) begin failures++; $display("FAIL steady_vld i=%0d got=%b exp=%b", i, qv4, i >= 4); end
    end
    vld = 0;
  endtask

  task automatic test_tap();
    logic [7:0] hist[$];
    en = 1;
    sel5 = 3'd2;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      vld = 1'($urandom);
      tick();
      hist.push_back(d);
      if (hist.size() >= 3) begin
        checks++; if (tap5 !== hist[hist.size()-3]) begin failures++; $display("FAIL tap2 i=%0d got=%h exp=%h", i, tap5, hist[hist.size()-3]); end
      end
    end
    for (int s = 5; s < 8; s++) begin
      sel5 = 3'(s);
      #1;
      checks++; if (tap5 !== RV5 || tv5 !== 1'b0) begin failures++; $display("FAIL tap_oor sel=%0d got=%h/%b exp=%h/0", s, tap5, tv5, RV5); end
    end
  endtask

  task automatic test_random();
    logic [7:0] et5;
    logic ev5;
    for (int i = 0; i < 1000; i++) begin
      en = ($urandom % 4) != 0;
      flush = ($urandom % 16) == 0;
      vld = 1'($urandom);
      d = 8'($urandom);
      sel4 = 2'($urandom);
      sel5 = 3'($urandom);
      tick();
      et5 = (sel5 < 5) ? m5[sel5] : RV5;
      ev5 = (sel5 < 5) ? v5[sel5] : 1'b0;
      checks++; if (cnt4 !== 3'($countones(v4))) begin failures++; $display("FAIL rnd_cnt4 i=%0d got=%0d exp=%0d", i, cnt4, $countones(v4)); end
      checks++; if (q4 !== m4[3] || qv4 !== v4[3]) begin failures++; $display("FAIL rnd_q4 i=%0d got=%h/%b exp=%h/%b", i, q4, qv4, m4[3], v4[3]); end
      checks++; if (tap4 !== m4[sel4] || tv4 !== v4[sel4]) begin failures++; $display("FAIL rnd_tap4 i=%0d got=%h/%b exp=%h/%b", i, tap4, tv4, m4[sel4], v4[sel4]); end
      checks++; if (cnt5 !== 3'($countones(v5))) begin failures++; $display("FAIL rnd_cnt5 i=%0d got=%0d exp=%0d", i, cnt5, $countones(v5)); end
      checks++; if (q5 !== m5[4] || qv5 !== v5[4]) begin failures++; $display("FAIL rnd_q5 i=%0d got=%h/%b exp=%h/%b", i, q5, qv5, m5[4], v5[4]); end
      checks++; if (tap5 !== et5 || tv5 !== ev5) begin failures++; $display("FAIL rnd_tap5 i=%0d got=%h/%b exp=%h/%b", i, tap5, tv5, et5, ev5); end
    end
    flush = 0;
  endtask

  initial begin
    clk = 0;
    rst = 1;
    en = 0;
    flush = 0;
    vld = 0;
    d = '0;
    sel4 = '0;
    sel5 = '0;
    model_reset();
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_steady();
    test_tap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
